updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
- Sequencer for a 4-bit up/down counter datapath.
- Generates `up_down` and a rate-controlled `step` strobe so the count sweeps as a triangle between programmable bounds `lo` and `hi`.
- Keeps a shadow position `pos` that mirrors the counter value.
- Supports single-sweep (`lo`→`hi`→`lo`, then done) and continuous modes. Sits between the host config/control logic and the counter datapath.

Parameters:
- `WIDTH`, 4, width of the position/bound values.
- `PRESC_W`, 8, width of the step-rate prescaler.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `stop`  input  1  abort the sweep; level-sampled each cycle.
- `mode`  input  1  0 = single sweep, 1 = continuous; latched at start.
- `lo`  input  WIDTH  lower bound; latched at start.
- `hi`  input  WIDTH  upper bound; latched at start.
- `presc`  input  PRESC_W  one step every `presc`+1 cycles; latched at start.
- `up_down`  output  1  direction to the counter: 1 = up, 0 = down.
- `step`  output  1  one-cycle strobe; the counter advances by 1 in `up_down` direction.
- `pos`  output  WIDTH  current position after the latest step.
- `busy`  output  1  high in UP or DOWN.
- `done`  output  1  one-cycle pulse when a single sweep completes.
- `cfg_err`  output  1  one-cycle pulse when `start` is rejected for `lo` >= `hi`.

Behaviour:
- Reset (synchronous, on `rst`=1 at a clock edge):
  - state=IDLE, `pos`=0, `up_down`=1, `step`=0, `busy`=0, `done`=0, `cfg_err`=0, prescale counter `tick`=0.
  - `rst` overrides all other inputs, including mid-sweep.
- All outputs are registered.
- States: IDLE, UP, DOWN, DONE.
- IDLE:
  - `start`=1 and `lo`<`hi`: latch `lo`/`hi`/`presc`/`mode`; `pos`<=`lo`; `tick`<=0; `up_down`<=1; → UP.
  - `start`=1 and `lo`>=`hi`: `cfg_err`=1 for one cycle; stay IDLE; `pos` unchanged.
- UP/DOWN prescaling:
  - `tick` increments every cycle.
  - When `tick`==latched `presc`: `tick`<=0 and a step occurs. `step`=1 in the same cycle that `pos` shows the new value.
  - First step occurs `presc`+1 cycles after the cycle in which `start` was accepted. `presc`=0 gives a step every cycle.
- UP step: `pos`<=`pos`+1. If the new `pos`==`hi`: → DOWN and `up_down`<=0, in the same cycle as the step.
- DOWN step: `pos`<=`pos`-1. If the new `pos`==`lo`:
  - `mode`=1: → UP, `up_down`<=1.
  - `mode`=0: → DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, → IDLE. `pos` holds `lo`.
- Single sweep: exactly 2*(`hi`-`lo`) steps.
- Arithmetic never wraps: `pos` stays within [`lo`,`hi`]. The 0/2^WIDTH-1 wrap of the counter is never exercised.
- `stop`=1 in UP/DOWN: → IDLE next edge with no step that cycle; `stop` wins over a coincident step. `pos` and `up_down` hold, `done` is not pulsed, `tick`<=0.
- `start` while busy: ignored. `stop` in IDLE/DONE: no effect.
- Bound changes after start: `lo`/`hi`/`presc`/`mode` are ignored until the next start.
- `busy`=1 exactly when state is UP or DOWN.

Decomposition:
- Shared package `updown_pkg`:
  - state enum (IDLE=2'd0, UP=2'd1, DOWN=2'd2, DONE=2'd3);
  - constants `DIR_UP`=1'b1, `DIR_DOWN`=1'b0;
  - default `WIDTH`/`PRESC_W`.
- One sub-module is natural: `step_prescaler`. It is a `PRESC_W` tick counter with load/clear and a terminal-count strobe.
- The FSM and `pos` tracking stay in the top module.
- Intended integration: `step` acts as the counter's clock enable, or alternatively `pos` is used directly as the count.

Test Plan:
1. `lo`=2, `hi`=5, `presc`=0, `mode`=0, `start` pulse → `pos` sequence 3,4,5,4,3,2 on consecutive cycles with `step`=1 each; `up_down` falls in the cycle `pos`=5; `done` pulses one cycle after `pos`=2; `busy` then low.
2. `lo`=0, `hi`=15, `presc`=3, `mode`=1 → `step` every 4 cycles; `pos` reaches 15 then 0 then 1 (no wrap); `done` never asserts over 40 steps.
3. `lo`=7, `hi`=7, `start` → `cfg_err`=1 for one cycle, `busy`=0, `pos` unchanged; repeat with `lo`=9, `hi`=4 → same.
4. Sweep `lo`=1, `hi`=8, `presc`=2, then `stop` asserted on the cycle a step is due at `pos`=4 → no step, `pos`=4 held, IDLE, no `done`; a new `start` restarts from `lo`.
5. `rst` asserted mid-sweep at `pos`=6 → next edge `pos`=0, `up_down`=1, `busy`=0; `start` pulses while busy are ignored.
6. `presc`=255 → first `step` exactly 256 cycles after `start` is accepted; changing `presc` mid-sweep leaves the rate unchanged.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared definitions for the up/down sweep sequencer.
//   state_t          : sequencer states
//   DIR_UP/DIR_DOWN  : encoding of the up_down direction line
//   WIDTH_DEF        : default position/bound width
//   PRESC_W_DEF      : default step-rate prescaler width
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int WIDTH_DEF   = 4;
    localparam int PRESC_W_DEF = 8;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: free-running tick counter that wraps at a latched
// terminal value and flags the terminal cycle.
//   clk, rst  : clock, synchronous active-high reset
//   load      : latch presc_in as the terminal value and zero the counter
//   clear     : zero the counter (terminal value kept)
//   en        : count this cycle
//   presc_in  : terminal value to latch on load
//   tc        : high in an enabled cycle whose count equals the terminal value
module step_prescaler
    import updown_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc_in,
    output logic               tc
);

    logic [PRESC_W-1:0] tick;
    logic [PRESC_W-1:0] presc_q;

    // Combinational so the sequencer can register the step in the same edge
    // that the counter wraps.
    assign tc = en && (tick == presc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            presc_q <= '0;
        end else if (load) begin
            tick    <= '0;
            presc_q <= presc_in;
        end else if (clear) begin
            tick <= '0;
        end else if (en) begin
            tick <= tc ? '0 : tick + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for a 4-bit up/down counter datapath.
// Drives direction and a rate-limited step strobe so the count runs
// lo -> hi -> lo, once (mode 0) or repeatedly (mode 1), and mirrors the
// counter value in pos.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a sweep (IDLE only); rejected with cfg_err if lo >= hi
//   stop      : abort a running sweep, position held
//   mode      : 0 single sweep, 1 continuous (latched at start)
//   lo, hi    : sweep bounds (latched at start)
//   presc     : one step every presc+1 cycles (latched at start)
//   up_down   : direction to the counter, 1 = up
//   step      : one-cycle advance strobe, coincident with the new pos
//   pos       : position after the latest step
//   busy      : sweep in progress
//   done      : one-cycle pulse after a single sweep completes
//   cfg_err   : one-cycle pulse when start is rejected
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [PRESC_W-1:0] presc,
    output logic               up_down,
    output logic               step,
    output logic [WIDTH-1:0]   pos,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t           state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             mode_q;

    logic             accept;
    logic             tc;
    logic [WIDTH-1:0] pos_inc;
    logic [WIDTH-1:0] pos_dec;

    assign accept  = (state == IDLE) && start && (lo < hi);
    assign pos_inc = pos + WIDTH'(1);
    assign pos_dec = pos - WIDTH'(1);

    // stop gates the prescaler so an abort never coincides with a step.
    step_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .clear    (stop),
        .en       (busy && !stop),
        .presc_in (presc),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pos     <= '0;
            up_down <= DIR_UP;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            step    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lo_q    <= lo;
                        hi_q    <= hi;
                        mode_q  <= mode;
                        pos     <= lo;
                        up_down <= DIR_UP;
                        busy    <= 1'b1;
                        state   <= UP;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                UP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tc) begin
                        step <= 1'b1;
                        pos  <= pos_inc;
                        if (pos_inc == hi_q) begin
                            up_down <= DIR_DOWN;
                            state   <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tc) begin
                        step <= 1'b1;
                        pos  <= pos_dec;
                        if (pos_dec == lo_q) begin
                            if (mode_q) begin
                                up_down <= DIR_UP;
                                state   <= UP;
                            end else begin
                                busy  <= 1'b0;
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    // done lands the cycle after the final step.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl. Inputs change and outputs are
// sampled on the falling edge; a small reference model tracks the expected
// position and direction across each step.
module tb_updown_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] presc;
    logic       up_down;
    logic       step;
    logic [3:0] pos;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_pos;
    int m_dir;
    int m_lo;
    int m_hi;
    int m_mode;
    int m_presc;

    updown_sweep_ctrl #(.WIDTH(4), .PRESC_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .presc   (presc),
        .up_down (up_down),
        .step    (step),
        .pos     (pos),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run n steps against the model: presc idle cycles with no step, then
    // one cycle with the step and the new position/direction.
    task automatic sweep_steps(input int n);
        for (int s = 0; s < n; s++) begin
            for (int w = 0; w < m_presc; w++) begin
                cyc();
                chk("idle_step", 32'(step), 0);
                chk("idle_done", 32'(done), 0);
            end
            if (m_dir == 1) begin
                m_pos++;
                if (m_pos == m_hi) m_dir = 0;
            end else begin
                m_pos--;
                if (m_pos == m_lo && m_mode == 1) m_dir = 1;
            end
            cyc();
            chk("step", 32'(step), 1);
            chk("pos", 32'(pos), 32'(m_pos));
            chk("up_down", 32'(up_down), 32'(m_dir));
            chk("step_done", 32'(done), 0);
        end
    endtask

    task automatic go(input int l, input int h, input int p, input int md);
        lo = 4'(l); hi = 4'(h); presc = 8'(p); mode = md[0]; start = 1'b1;
        m_lo = l; m_hi = h; m_presc = p; m_mode = md; m_pos = l; m_dir = 1;
        cyc();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 1);
        chk("accept_pos", 32'(pos), 32'(l));
        chk("accept_step", 32'(step), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        lo = '0; hi = '0; presc = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_pos", 32'(pos), 0);
        chk("rst_up_down", 32'(up_down), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);

        // single sweep 2..5, a step every cycle: 3,4,5,4,3,2
        go(2, 5, 0, 0);
        sweep_steps(6);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_done_early", 32'(done), 0);
        cyc();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_step", 32'(step), 0);
        cyc();
        chk("t1_done_once", 32'(done), 0);
        chk("t1_pos_hold", 32'(pos), 2);

        // rejected configurations
        lo = 4'd7; hi = 4'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t3a_cfg_err", 32'(cfg_err), 1);
        chk("t3a_busy", 32'(busy), 0);
        chk("t3a_pos", 32'(pos), 2);
        cyc();
        chk("t3a_cfg_err_once", 32'(cfg_err), 0);
        lo = 4'd9; hi = 4'd4; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t3b_cfg_err", 32'(cfg_err), 1);
        chk("t3b_busy", 32'(busy), 0);
        chk("t3b_pos", 32'(pos), 2);
        cyc();
        chk("t3b_cfg_err_once", 32'(cfg_err), 0);

        // continuous full-range sweep, step every 4 cycles, no wrap, no done
        go(0, 15, 3, 1);
        sweep_steps(40);
        chk("t2_pos_end", 32'(pos), 10);
        chk("t2_busy", 32'(busy), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t2_stop_busy", 32'(busy), 0);
        chk("t2_stop_pos", 32'(pos), 10);

        // stop exactly when the step from 4 to 5 is due
        go(1, 8, 2, 0);
        sweep_steps(3);
        cyc();
        chk("t4_wait0", 32'(step), 0);
        cyc();
        chk("t4_wait1", 32'(step), 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4_stop_step", 32'(step), 0);
        chk("t4_stop_pos", 32'(pos), 4);
        chk("t4_stop_busy", 32'(busy), 0);
        chk("t4_stop_dir", 32'(up_down), 1);
        chk("t4_stop_done", 32'(done), 0);
        cyc();
        chk("t4_idle_pos", 32'(pos), 4);
        chk("t4_idle_done", 32'(done), 0);
        chk("t4_idle_busy", 32'(busy), 0);

        // restart from lo; start held and bounds changed while busy are ignored
        go(1, 8, 2, 0);
        start = 1'b1; lo = 4'd0; hi = 4'd3; presc = 8'd0; mode = 1'b1;
        sweep_steps(9);
        start = 1'b0;
        chk("t5_pos_pre", 32'(pos), 6);
        chk("t5_dir_pre", 32'(up_down), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_rst_pos", 32'(pos), 0);
        chk("t5_rst_dir", 32'(up_down), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_step", 32'(step), 0);

        // slowest rate; presc input changed after start has no effect
        go(3, 5, 255, 0);
        presc = 8'd0;
        sweep_steps(2);
        chk("t6_dir", 32'(up_down), 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t6_stop_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
